hex_text_writer: RTL and testbench
==================================

Name: hex_text_writer

Overview:
Drives the eight DE2 seven-segment displays (HEX7..HEX0) from a stream of ASCII characters. It is the encode side of the display path that the bench decodes back to ASCII.
- Holds an 8-character display buffer.
- Characters arrive over a valid/ready handshake, written by position or shifted in from the right.
- Supports a multi-cycle clear sweep and per-digit blinking for edit mode.
- Sits between the clock/edit-mode control logic and the HEX pins.

Parameters:
BLINK_DIV, 25000000, clock cycles per blink half-period (minimum 2).

Ports:
CLOCK_50  in  1  system clock; all state changes on its rising edge.
RESET  in  1  asynchronous, active-high reset.
char_valid  in  1  char_data, char_pos and char_shift are valid this cycle.
char_ready  out  1  block can accept a character this cycle.
char_data  in  8  ASCII code.
char_pos  in  3  target digit in positional mode; 0 = HEX0 (rightmost), 7 = HEX7.
char_shift  in  1  1 = shift-in mode (char_pos ignored); 0 = positional mode.
clear  in  1  request a clear sweep; sampled only when the FSM is in IDLE.
blink_mask  in  8  bit i set = HEXi blinks.
err  out  1  sticky flag: an unsupported character was written.
HEX0..HEX7  out  [0:6] each  active-low segments a..g; bit 0 = segment a.

Behaviour:
- Reset, asserted asynchronously:
  - All eight buffer digits = 7'b111_1111 (blank). HEX outputs therefore read 7'b111_1111.
  - err = 0, state = IDLE, blink counter = 0, blink phase = 0.
  - char_ready = 0 while RESET is high.
- Encoding, in [0:6] order:
  - '0' 000_0001, '1' 100_1111, '2' 001_0010, '3' 000_0110, '4' 100_1100.
  - '5' 010_0100, '6' 010_0000, '7' 000_1111, '8' 000_0000, '9' 000_0100.
  - 'A' 000_1000, 'P' 001_1000, '-' 111_1110, ' ' 111_1111.
  - Any other code encodes to 111_1111 and sets err on the write.
- FSM states: IDLE, WRITE, CLEAR.
- char_ready = (state == IDLE) && !clear && !RESET. It is combinational.
- IDLE:
  - If clear = 1: go to CLEAR with sweep index = 0. clear has priority, so no character is accepted that cycle even if char_valid = 1.
  - Else if char_valid && char_ready: latch the encoded segments, char_pos and char_shift into stage registers, then go to WRITE.
- WRITE, one cycle: commit the stage register to the buffer, then return to IDLE.
  - Positional mode: buf[char_pos] <= seg.
  - Shift mode: buf[7..1] <= buf[6..0] and buf[0] <= seg.
  - If the character was unsupported, err <= 1.
- Latency and throughput:
  - A character accepted at edge N is visible on HEX after edge N+1.
  - Throughput is one character every 2 cycles; char_ready is low during WRITE.
- CLEAR:
  - One digit per cycle: buf[idx] <= blank, idx increments 0..7.
  - At idx = 7, blank the digit, set err <= 0, and go to IDLE.
  - Eight cycles in total with char_ready low; clear is ignored while in CLEAR.
- Blink:
  - The free-running counter counts 0..BLINK_DIV-1.
  - On wrap it resets to 0 and toggles the blink phase.
  - HEXi = (blink_phase && blink_mask[i]) ? 111_1111 : buf[i]. The output is combinational from registers.
  - Blinking never alters buffer contents.
- Reset mid-CLEAR or mid-WRITE: the operation is aborted immediately and the full reset state is restored. No partial write survives.
- char_valid held high with char_ready low: no side effect. The sender holds its data until ready.
- Shift mode with a full buffer: buf[7] is discarded. There is no wrap-around.

Test Plan:
1. Reset, then write '1' at char_pos = 7 in positional mode. Required: char_ready low for exactly 1 cycle after acceptance; HEX7 = 100_1111 after edge N+1; all other digits 111_1111; err = 0.
2. Shift in '1' then '2' back-to-back with char_valid held high. Required: HEX1 = 100_1111, HEX0 = 001_0010; acceptances spaced exactly 2 cycles apart.
3. Write 'Z' at char_pos = 3 in positional mode. Required: HEX3 = 111_1111 and err = 1. Then write '5' at char_pos = 3. Required: HEX3 = 010_0100 and err remains 1.
4. Load all digits with '8', then pulse clear in the same cycle as char_valid. Required: the character is not accepted; char_ready low for 8 cycles; HEX0..HEX7 blanked in index order, one per cycle; err = 0 at the end.
5. Use BLINK_DIV = 4 with HEX0 = '0' and blink_mask = 8'h01. Required: HEX0 alternates 000_0001 / 111_1111 every 4 cycles; HEX1..7 are unaffected; after clearing the mask, HEX0 shows 000_0001 steadily.
6. Assert RESET on the 4th cycle of CLEAR, with RESET asynchronous to the clock edge. Required: outputs are immediately blank, char_ready = 0 and err = 0; after release, char_ready = 1 in IDLE.

Source files
------------

// File: rtl/hex_text_writer.sv
// hex_text_writer: 8-digit seven-segment text buffer for the DE2 HEX7..HEX0 displays.
// Accepts ASCII characters over a valid/ready handshake, either written to a
// chosen digit or shifted in from the right. It also provides a one-digit-per-cycle
// clear sweep and per-digit blinking, which is used to highlight the digit being edited.
module hex_text_writer #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic [7:0] char_data,
  input  logic [2:0] char_pos,
  input  logic       char_shift,
  input  logic       clear,
  input  logic [7:0] blink_mask,
  output logic       err,
  output logic [0:6] HEX0,
  output logic [0:6] HEX1,
  output logic [0:6] HEX2,
  output logic [0:6] HEX3,
  output logic [0:6] HEX4,
  output logic [0:6] HEX5,
  output logic [0:6] HEX6,
  output logic [0:6] HEX7
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;

  // Active-low segments: all ones is a dark digit.
  localparam logic [0:6] BLANK = 7'b111_1111;

  localparam int                CNT_W   = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(BLINK_DIV - 1);

  logic [1:0]       state;
  logic [2:0]       clr_idx;
  logic [0:6]       stage_seg;
  logic [2:0]       stage_pos;
  logic             stage_shift;
  logic             stage_bad;
  logic [0:6]       digit_buf [8];
  logic [CNT_W-1:0] blink_cnt;
  logic             blink_phase;

  logic [0:6]       enc_seg;
  logic             enc_bad;
  logic [0:6]       hex_out [8];

  // Only accept in IDLE; a pending clear request wins over a character.
  assign char_ready = (state == IDLE) && !clear && !RESET;

  // ASCII to active-low segment pattern, flagging codes we cannot display.
  always_comb begin
    enc_seg = BLANK;
    enc_bad = 1'b0;
    case (char_data)
      "0":     enc_seg = 7'b000_0001;
      "1":     enc_seg = 7'b100_1111;
      "2":     enc_seg = 7'b001_0010;
      "3":     enc_seg = 7'b000_0110;
      "4":     enc_seg = 7'b100_1100;
      "5":     enc_seg = 7'b010_0100;
      "6":     enc_seg = 7'b010_0000;
      "7":     enc_seg = 7'b000_1111;
      "8":     enc_seg = 7'b000_0000;
      "9":     enc_seg = 7'b000_0100;
      "A":     enc_seg = 7'b000_1000;
      "P":     enc_seg = 7'b001_1000;
      "-":     enc_seg = 7'b111_1110;
      " ":     enc_seg = BLANK;
      default: begin
        enc_seg = BLANK;
        enc_bad = 1'b1;
      end
    endcase
  end

  // Control FSM: stage an accepted character, commit it next cycle, or sweep-clear the buffer.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      clr_idx     <= 3'd0;
      stage_seg   <= BLANK;
      stage_pos   <= 3'd0;
      stage_shift <= 1'b0;
      stage_bad   <= 1'b0;
      err         <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        digit_buf[i] <= BLANK;
      end
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            clr_idx <= 3'd0;
            state   <= CLEAR;
          end else if (char_valid && char_ready) begin
            stage_seg   <= enc_seg;
            stage_bad   <= enc_bad;
            stage_pos   <= char_pos;
            stage_shift <= char_shift;
            state       <= WRITE;
          end
        end
        WRITE: begin
          if (stage_shift) begin
            // Oldest digit (HEX7) falls off the left edge; no wrap-around.
            for (int i = 7; i > 0; i--) begin
              digit_buf[i] <= digit_buf[i-1];
            end
            digit_buf[0] <= stage_seg;
          end else begin
            digit_buf[stage_pos] <= stage_seg;
          end
          if (stage_bad) begin
            err <= 1'b1;
          end
          state <= IDLE;
        end
        CLEAR: begin
          digit_buf[clr_idx] <= BLANK;
          if (clr_idx == 3'd7) begin
            err   <= 1'b0;
            state <= IDLE;
          end else begin
            clr_idx <= clr_idx + 3'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Free-running blink timebase: phase toggles once per BLINK_DIV cycles.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == CNT_MAX) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Blinking only masks the output; the buffer itself is never touched.
  for (genvar gi = 0; gi < 8; gi++) begin : g_hex
    assign hex_out[gi] = (blink_phase && blink_mask[gi]) ? BLANK : digit_buf[gi];
  end

  assign HEX0 = hex_out[0];
  assign HEX1 = hex_out[1];
  assign HEX2 = hex_out[2];
  assign HEX3 = hex_out[3];
  assign HEX4 = hex_out[4];
  assign HEX5 = hex_out[5];
  assign HEX6 = hex_out[6];
  assign HEX7 = hex_out[7];

endmodule

// File: tb/tb_hex_text_writer.sv
// tb_hex_text_writer: directed stimulus for hex_text_writer. An edge-scheduled
// behavioural model of the display is checked against the DUT on every cycle,
// and hand-computed literal checks are made at key points.
module tb_hex_text_writer;

  localparam int         BDIV  = 4;
  localparam logic [0:6] BLANK = 7'b111_1111;
  localparam logic [0:6] SEG_0 = 7'b000_0001;
  localparam logic [0:6] SEG_1 = 7'b100_1111;
  localparam logic [0:6] SEG_2 = 7'b001_0010;
  localparam logic [0:6] SEG_5 = 7'b010_0100;
  localparam logic [0:6] SEG_7 = 7'b000_1111;
  localparam logic [0:6] SEG_8 = 7'b000_0000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       char_valid = 1'b0;
  logic       char_shift = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic [2:0] char_pos = 3'd0;
  logic [7:0] blink_mask = 8'h00;
  logic       char_ready;
  logic       err;
  logic [0:6] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
  logic [0:6] hx [8];

  hex_text_writer #(.BLINK_DIV(BDIV)) dut (
    .CLOCK_50  (clk),
    .RESET     (rst),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .char_data (char_data),
    .char_pos  (char_pos),
    .char_shift(char_shift),
    .clear     (clear),
    .blink_mask(blink_mask),
    .err       (err),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
    .HEX4(HEX4), .HEX5(HEX5), .HEX6(HEX6), .HEX7(HEX7)
  );

  assign hx[0] = HEX0;
  assign hx[1] = HEX1;
  assign hx[2] = HEX2;
  assign hx[3] = HEX3;
  assign hx[4] = HEX4;
  assign hx[5] = HEX5;
  assign hx[6] = HEX6;
  assign hx[7] = HEX7;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Character table: returns {unsupported, segments[0:6]}.
  function automatic logic [7:0] enc(input logic [7:0] c);
    case (c)
      "0": return {1'b0, 7'b000_0001};
      "1": return {1'b0, 7'b100_1111};
      "2": return {1'b0, 7'b001_0010};
      "3": return {1'b0, 7'b000_0110};
      "4": return {1'b0, 7'b100_1100};
      "5": return {1'b0, 7'b010_0100};
      "6": return {1'b0, 7'b010_0000};
      "7": return {1'b0, 7'b000_1111};
      "8": return {1'b0, 7'b000_0000};
      "9": return {1'b0, 7'b000_0100};
      "A": return {1'b0, 7'b000_1000};
      "P": return {1'b0, 7'b001_1000};
      "-": return {1'b0, 7'b111_1110};
      " ": return {1'b0, 7'b111_1111};
      default: return {1'b1, 7'b111_1111};
    endcase
  endfunction

  // ---------------- behavioural model (edge-indexed schedule) ----------------
  logic [0:6] m_seg [8];
  bit         m_err;
  int         edge_n;       // index of the next clock edge since reset release
  int         free_at;      // first edge at which a new request may be taken
  bit         wr_pend;
  logic [0:6] wr_seg;
  bit         wr_bad;
  bit         wr_shift;
  int         wr_pos;
  bit         clr_active;
  int         clr_start;
  int         accepts = 0;
  int         dut_last_acc = 0;
  int         dut_prev_acc = 0;

  always @(posedge rst) begin : model_reset
    for (int i = 0; i < 8; i++) m_seg[i] = BLANK;
    m_err      = 1'b0;
    edge_n     = 0;
    free_at    = 0;
    wr_pend    = 1'b0;
    clr_active = 1'b0;
  end

  always @(posedge clk) begin : model_step
    int e;
    logic [7:0] r;
    if (!rst) begin
      e = edge_n;
      edge_n++;
      if (wr_pend) begin
        if (wr_shift) begin
          for (int i = 7; i > 0; i--) m_seg[i] = m_seg[i-1];
          m_seg[0] = wr_seg;
        end else begin
          m_seg[wr_pos] = wr_seg;
        end
        if (wr_bad) m_err = 1'b1;
        wr_pend = 1'b0;
      end
      if (clr_active) begin
        m_seg[e - clr_start - 1] = BLANK;
        if (e - clr_start == 8) begin
          m_err      = 1'b0;
          clr_active = 1'b0;
        end
      end
      if (e >= free_at) begin
        if (clear) begin
          clr_active = 1'b1;
          clr_start  = e;
          free_at    = e + 9;
        end else if (char_valid) begin
          r        = enc(char_data);
          wr_pend  = 1'b1;
          wr_seg   = r[6:0];
          wr_bad   = r[7];
          wr_pos   = int'(char_pos);
          wr_shift = char_shift;
          free_at  = e + 2;
          accepts++;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin : compare
    bit         ph;
    logic [0:6] ex;
    if (chk_en) begin
      ph = ((edge_n / BDIV) % 2) == 1;
      for (int i = 0; i < 8; i++) begin
        ex = (ph && blink_mask[i]) ? BLANK : m_seg[i];
        chk($sformatf("cyc_HEX%0d", i), hx[i], ex);
      end
      chk("cyc_err", err, m_err);
      chk("cyc_ready", char_ready, !rst && (edge_n >= free_at) && !clear);
      if (char_valid && char_ready) begin
        dut_prev_acc = dut_last_acc;
        dut_last_acc = edge_n;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c, input int pos, input bit sh);
    int a0;
    a0 = accepts;
    char_valid = 1'b1;
    char_data  = c;
    char_pos   = pos[2:0];
    char_shift = sh;
    for (int i = 0; i < 20 && accepts == a0; i++) tick();
    if (accepts == a0) begin
      n_checks++;
      $display("FAIL accept_timeout: char %c not accepted within 20 cycles", c);
    end else begin
      $display("send '%c' pos=%0d shift=%0d accepted at edge %0d", c, pos, sh, edge_n - 1);
    end
    char_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [0:6] v;
    int n;
    // Reset
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    chk("rst_hex0", HEX0, BLANK);
    chk("rst_ready", char_ready, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    tick();
    chk("rst_hex7", HEX7, BLANK);
    chk("rst_err", err, 1'b0);
    chk("idle_ready", char_ready, 1'b1);

    // Test 1: positional write to HEX7
    send("1", 7, 1'b0);
    chk("t1_ready_low", char_ready, 1'b0);
    chk("t1_hex7_pre", HEX7, BLANK);
    tick();
    chk("t1_hex7", HEX7, SEG_1);
    chk("t1_hex6", HEX6, BLANK);
    chk("t1_ready_back", char_ready, 1'b1);
    chk("t1_err", err, 1'b0);

    // Test 2: back-to-back shift-in
    send("1", 0, 1'b1);
    send("2", 0, 1'b1);
    chk("t2_spacing", dut_last_acc - dut_prev_acc, 2);
    tick();
    chk("t2_hex1", HEX1, SEG_1);
    chk("t2_hex0", HEX0, SEG_2);

    // Test 3: unsupported character sets sticky err
    send("9", 3, 1'b0);
    send("Z", 3, 1'b0);
    tick();
    chk("t3_hex3_blank", HEX3, BLANK);
    chk("t3_err_set", err, 1'b1);
    send("5", 3, 1'b0);
    tick();
    chk("t3_hex3_5", HEX3, SEG_5);
    chk("t3_err_sticky", err, 1'b1);

    // Test 4: fill with '8', then clear together with a valid character
    for (int i = 0; i < 8; i++) send("8", i, 1'b0);
    tick();
    chk("t4_hex7_8", HEX7, SEG_8);
    char_valid = 1'b1;
    char_data  = "9";
    char_pos   = 3'd0;
    char_shift = 1'b0;
    clear      = 1'b1;
    #1;
    chk("t4_ready_clear", char_ready, 1'b0);
    tick();
    clear      = 1'b0;
    char_valid = 1'b0;
    $display("clear requested, sweep started at edge %0d", edge_n - 1);
    chk("t4_ready_sweep0", char_ready, 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("t4_blank%0d", k), hx[k], BLANK);
      if (k < 7) chk($sformatf("t4_keep%0d", k + 1), hx[k+1], SEG_8);
      chk($sformatf("t4_ready%0d", k), char_ready, (k == 7));
    end
    chk("t4_err_cleared", err, 1'b0);

    // Test 5: blink HEX0 with BLINK_DIV = 4
    send("0", 0, 1'b0);
    send("7", 1, 1'b0);
    tick();
    blink_mask = 8'h01;
    #1;
    v = HEX0;
    n = 0;
    while (HEX0 == v && n < 12) begin
      tick();
      n++;
    end
    if (n == 12) begin
      n_checks++;
      $display("FAIL t5_no_toggle: HEX0 stuck at %b", v);
    end
    v = HEX0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_hold", HEX0, v);
    end
    tick();
    chk("t5_toggle", HEX0, (v == SEG_0) ? BLANK : SEG_0);
    chk("t5_hex1", HEX1, SEG_7);
    blink_mask = 8'h00;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("t5_steady", HEX0, SEG_0);
      tick();
    end

    // Test 6: asynchronous reset in the 4th cycle of a clear sweep
    send("8", 7, 1'b0);
    send("Z", 2, 1'b0);
    tick();
    chk("t6_err_pre", err, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    tick();
    tick();
    #2 rst = 1'b1;
    $display("reset asserted mid-clear at t=%0t", $time);
    #1;
    for (int i = 0; i < 8; i++) chk($sformatf("t6_blank%0d", i), hx[i], BLANK);
    chk("t6_err", err, 1'b0);
    chk("t6_ready", char_ready, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    chk("t6_ready_idle", char_ready, 1'b1);
    chk("t6_hex7", HEX7, BLANK);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
